// File: rtl/fifo_uart_tx_if.sv
// FIFO read port seen by the UART transmitter.
// The transmitter is master: it issues the pop, the FIFO answers.
interface fifo_uart_tx_if;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_read_en;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_read_en
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_read_en
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a registered-output FIFO, one byte per frame.
// 8N1 framing with optional even parity; tx comes straight from a flop.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tx_enable,
    fifo_uart_tx_if.master fifo,
    output logic           tx,
    output logic           busy,
    output logic [7:0]     bytes_sent
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, START, DATA, PARITY, STOP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic [7:0]    sent_q, sent_d;
    logic          bit_end;

    assign bit_end = (cnt_q == CNT_MAX);

    // tx_d is the line level for the state being entered, so tx
    // changes on the same edge as the state register.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        sent_d  = sent_q;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_enable && !fifo.fifo_empty)
                    state_d = FETCH;
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                shreg_d = fifo.fifo_data;
                bit_d   = '0;
                tx_d    = 1'b0;
                state_d = START;
            end
            START: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    tx_d    = shreg_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    // Rotate so the register still holds all 8 bits for parity.
                    shreg_d = {shreg_q[0], shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        if (PARITY_EN) begin
                            tx_d    = ^shreg_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        tx_d = shreg_q[1];
                    end
                end
            end
            PARITY: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    sent_d  = sent_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            sent_q  <= sent_d;
        end
    end

    assign fifo.fifo_read_en = (state_q == FETCH);
    assign tx                = tx_q;
    assign busy              = (state_q != IDLE);
    assign bytes_sent        = sent_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: an 8N1 instance and an even-parity instance,
// each fed by a FIFO model, checked against an ideal UART frame model.
module tb_fifo_uart_tx;

    localparam int C = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tx_enable = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   sel = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fifo_uart_tx_if if0 ();
    fifo_uart_tx_if if1 ();

    logic       tx0, busy0, tx1, busy1;
    logic [7:0] sent0, sent1;

    fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .tx_enable(tx_enable), .fifo(if0),
        .tx(tx0), .busy(busy0), .bytes_sent(sent0)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .tx_enable(tx_enable), .fifo(if1),
        .tx(tx1), .busy(busy1), .bytes_sent(sent1)
    );

    // FIFO models: read data appears one edge after the pop.
    logic [7:0] mem0 [1024];
    logic [7:0] mem1 [1024];
    int         wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
    logic [7:0] fd0 = 8'h00, fd1 = 8'h00;

    always @(posedge clk) begin
        if (if0.fifo_read_en) begin
            fd0 <= mem0[rd0];
            rd0 <= rd0 + 1;
        end
        if (if1.fifo_read_en) begin
            fd1 <= mem1[rd1];
            rd1 <= rd1 + 1;
        end
    end

    assign if0.fifo_data  = fd0;
    assign if0.fifo_empty = (wr0 == rd0);
    assign if1.fifo_data  = fd1;
    assign if1.fifo_empty = (wr1 == rd1);

    logic       rd_s, tx_s, busy_s;
    logic [7:0] sent_s;
    assign rd_s   = (sel != 0) ? if1.fifo_read_en : if0.fifo_read_en;
    assign tx_s   = (sel != 0) ? tx1 : tx0;
    assign busy_s = (sel != 0) ? busy1 : busy0;
    assign sent_s = (sel != 0) ? sent1 : sent0;

    logic [7:0] exp0 = 8'd0, exp1 = 8'd0;

    task automatic push(input int d, input logic [7:0] b);
        if (d == 0) begin
            mem0[wr0] = b;
            wr0++;
        end else begin
            mem1[wr1] = b;
            wr1++;
        end
    endtask

    // Ideal line level for serial bit slot i of a frame.
    function automatic logic frame_bit(input logic [7:0] b, input int pe,
                                       input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (i == 9 && pe != 0) return ^b;
        return 1'b1;
    endfunction

    // Waits for a pop, then checks the whole frame cycle by cycle.
    task automatic run_frame(input int d, input logic [7:0] b,
                             input int drop_at, output int t_fetch);
        int pe, n, waited, bad;
        logic e;
        pe = (d != 0) ? 1 : 0;
        sel = d;
        waited = 0;
        t_fetch = -1;
        @(negedge clk);
        while (rd_s !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (rd_s !== 1'b1) begin
            failures++;
            $display("FAIL fetch_timeout dut%0d byte %h: read_en=%b want 1",
                     d, b, rd_s);
            return;
        end
        t_fetch = cyc;
        @(negedge clk);
        bad = 0;
        if (tx_s !== 1'b1 || busy_s !== 1'b1 || rd_s !== 1'b0) begin
            bad = 1;
            $display("FAIL latch_cycle dut%0d: tx=%b busy=%b rd=%b want 1 1 0",
                     d, tx_s, busy_s, rd_s);
        end
        n = (10 + pe) * C;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == drop_at) tx_enable = 1'b0;
            e = frame_bit(b, pe, k / C);
            if ((tx_s !== e || busy_s !== 1'b1 || rd_s !== 1'b0) && bad == 0) begin
                bad = 1;
                $display("FAIL frame_bits dut%0d byte %h cyc %0d: tx=%b busy=%b rd=%b want %b 1 0",
                         d, b, k, tx_s, busy_s, rd_s, e);
            end
        end
        checks++;
        if (bad != 0) failures++;
        @(negedge clk);
        if (d == 0) exp0 = exp0 + 8'd1;
        else        exp1 = exp1 + 8'd1;
        checks++;
        if (busy_s !== 1'b0 || tx_s !== 1'b1) begin
            failures++;
            $display("FAIL idle_after dut%0d: busy=%b tx=%b want 0 1",
                     d, busy_s, tx_s);
        end
        checks++;
        if (sent_s !== ((d == 0) ? exp0 : exp1)) begin
            failures++;
            $display("FAIL bytes_sent dut%0d: got %0d want %0d",
                     d, sent_s, (d == 0) ? exp0 : exp1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx0, busy0, if0.fifo_read_en, sent0} !== {3'b100, 8'd0}) begin
            failures++;
            $display("FAIL reset_dut0: tx/busy/rd/sent=%b/%b/%b/%0d want 1/0/0/0",
                     tx0, busy0, if0.fifo_read_en, sent0);
        end
        checks++;
        if ({tx1, busy1, if1.fifo_read_en, sent1} !== {3'b100, 8'd0}) begin
            failures++;
            $display("FAIL reset_dut1: tx/busy/rd/sent=%b/%b/%b/%0d want 1/0/0/0",
                     tx1, busy1, if1.fifo_read_en, sent1);
        end
        reset = 1'b1;
        tx_enable = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || if0.fifo_read_en !== 1'b0) begin
            failures++;
            $display("FAIL empty_idle: busy=%b rd=%b want 0 0",
                     busy0, if0.fifo_read_en);
        end
    endtask

    task automatic test_single();
        int t;
        push(0, 8'hA5);
        run_frame(0, 8'hA5, -1, t);
    endtask

    task automatic test_back_to_back();
        int t, tp, bad;
        for (int i = 1; i <= 8; i++) push(0, 8'(i));
        tp = -1;
        bad = 0;
        for (int i = 1; i <= 8; i++) begin
            run_frame(0, 8'(i), -1, t);
            if (tp >= 0 && t - tp != 10 * C + 3 && bad == 0) begin
                bad = 1;
                $display("FAIL fetch_spacing: got %0d want %0d", t - tp, 10 * C + 3);
            end
            tp = t;
        end
        checks++;
        if (bad != 0) failures++;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy0 !== 1'b0 || if0.fifo_read_en !== 1'b0) bad = 1;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL idle_when_empty: busy=%b rd=%b want 0 0",
                     busy0, if0.fifo_read_en);
        end
    endtask

    task automatic test_parity();
        int t;
        logic [7:0] b;
        push(1, 8'h07);
        push(1, 8'h03);
        run_frame(1, 8'h07, -1, t);
        run_frame(1, 8'h03, -1, t);
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 255));
            push(1, b);
            run_frame(1, b, -1, t);
        end
    endtask

    task automatic test_random();
        int t;
        logic [7:0] b;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            push(0, b);
            run_frame(0, b, -1, t);
        end
    endtask

    task automatic test_enable_drop();
        int t, bad;
        push(0, 8'h55);
        push(0, 8'h66);
        run_frame(0, 8'h55, 4 * C + 2, t);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy0 !== 1'b0 || if0.fifo_read_en !== 1'b0) bad = 1;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL enable_gate: busy=%b rd=%b want 0 0",
                     busy0, if0.fifo_read_en);
        end
        tx_enable = 1'b1;
        run_frame(0, 8'h66, -1, t);
    endtask

    task automatic test_reset_mid();
        int t, waited;
        sel = 0;
        push(0, 8'hFF);
        push(0, 8'h3C);
        waited = 0;
        @(negedge clk);
        while (if0.fifo_read_en !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        repeat (C + 3 * C + 1) @(negedge clk);
        checks++;
        if (busy0 !== 1'b1 || tx0 !== 1'b1) begin
            failures++;
            $display("FAIL mid_frame_pre: busy=%b tx=%b want 1 1", busy0, tx0);
        end
        reset = 1'b0;
        @(negedge clk);
        exp0 = 8'd0;
        exp1 = 8'd0;
        checks++;
        if ({tx0, busy0, if0.fifo_read_en, sent0} !== {3'b100, 8'd0}) begin
            failures++;
            $display("FAIL mid_frame_abort: tx/busy/rd/sent=%b/%b/%b/%0d want 1/0/0/0",
                     tx0, busy0, if0.fifo_read_en, sent0);
        end
        @(negedge clk);
        reset = 1'b1;
        run_frame(0, 8'h3C, -1, t);
    endtask

    task automatic test_wrap();
        int t, guard;
        logic [7:0] b;
        guard = 0;
        while (exp0 != 8'd255 && guard < 300) begin
            b = 8'($urandom_range(0, 255));
            push(0, b);
            run_frame(0, b, -1, t);
            guard++;
        end
        checks++;
        if (sent0 !== 8'd255) begin
            failures++;
            $display("FAIL count_255: got %0d want 255", sent0);
        end
        push(0, 8'hC3);
        run_frame(0, 8'hC3, -1, t);
        checks++;
        if (sent0 !== 8'd0) begin
            failures++;
            $display("FAIL count_wrap: got %0d want 0", sent0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_random();
        test_enable_drop();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
